// File: rtl/spdif_rx_decoder.sv
// S/PDIF biphase-mark receiver: measures transition intervals, locks to B/M/W preambles
// and emits one decoded 24-bit sample with V/U/C flags per subframe.
module spdif_rx_decoder #(
  parameter logic [7:0] SHORT_MIN = 8'd8,
  parameter logic [7:0] SHORT_MAX = 8'd24,
  parameter logic [7:0] MED_MAX   = 8'd40,
  parameter logic [7:0] LONG_MAX  = 8'd57
) (
  input  logic        clk_100mhz,
  input  logic        rst,
  input  logic        spdif_in,
  output logic [23:0] sample,
  output logic        sample_valid,
  output logic        is_right,
  output logic        block_start,
  output logic        v_bit,
  output logic        u_bit,
  output logic        c_bit,
  output logic        parity_err,
  output logic        frame_err,
  output logic        locked
);

  typedef enum logic [1:0] {HUNT, PRE, DATA, DONE} state_t;
  typedef enum logic [1:0] {IV_S, IV_M, IV_L, IV_X} ival_t;
  typedef enum logic [1:0] {PT_B, PT_M, PT_W} pre_t;

  logic        sync1, sync2, sync_prev;
  logic        edge_det;
  logic [7:0]  ival_cnt;
  ival_t       ival;
  state_t      state;
  logic [1:0]  pulse_idx;
  ival_t       pre_second;
  pre_t        pre_type;
  pre_t        pre_found;
  logic        pre_ok, pre_match;
  logic [27:0] shreg;
  logic [5:0]  bit_idx;
  logic        half_flag;
  logic        parity;
  logic        bit_done, bit_val, data_bad;

  assign edge_det = sync2 ^ sync_prev;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      ival_cnt  <= '0;
    end else begin
      sync1     <= spdif_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      if (edge_det)
        ival_cnt <= 8'd1;
      else if (ival_cnt != 8'hFF)
        ival_cnt <= ival_cnt + 8'd1;
    end
  end

  always_comb begin
    ival = IV_X;
    if (ival_cnt >= SHORT_MIN && ival_cnt <= SHORT_MAX)
      ival = IV_S;
    else if (ival_cnt > SHORT_MAX && ival_cnt <= MED_MAX)
      ival = IV_M;
    else if (ival_cnt > MED_MAX && ival_cnt <= LONG_MAX)
      ival = IV_L;
  end

  // pulse_idx counts preamble intervals already closed; the third one is always S,
  // so the second and fourth together identify B (S..L), M (L..S) or W (M..M).
  always_comb begin
    pre_ok    = 1'b0;
    pre_match = 1'b0;
    pre_found = PT_B;
    case (pulse_idx)
      2'd0: pre_ok = (ival == IV_L);
      2'd1: pre_ok = (ival != IV_X);
      2'd2: pre_ok = (ival == IV_S);
      default: begin
        pre_ok    = 1'b1;
        pre_match = 1'b1;
        if (pre_second == IV_S && ival == IV_L)
          pre_found = PT_B;
        else if (pre_second == IV_L && ival == IV_S)
          pre_found = PT_M;
        else if (pre_second == IV_M && ival == IV_M)
          pre_found = PT_W;
        else begin
          pre_ok    = 1'b0;
          pre_match = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    bit_done = 1'b0;
    bit_val  = 1'b0;
    data_bad = 1'b0;
    case (ival)
      IV_S: if (half_flag) begin
        bit_done = 1'b1;
        bit_val  = 1'b1;
      end
      IV_M: if (half_flag) data_bad = 1'b1;
            else           bit_done = 1'b1;
      default: data_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state        <= HUNT;
      pulse_idx    <= '0;
      pre_second   <= IV_X;
      pre_type     <= PT_B;
      shreg        <= '0;
      bit_idx      <= '0;
      half_flag    <= 1'b0;
      parity       <= 1'b0;
      sample       <= '0;
      is_right     <= 1'b0;
      block_start  <= 1'b0;
      v_bit        <= 1'b0;
      u_bit        <= 1'b0;
      c_bit        <= 1'b0;
      sample_valid <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        HUNT: if (edge_det && ival == IV_L) begin
          state     <= PRE;
          pulse_idx <= 2'd1;
        end
        PRE: if (edge_det) begin
          if (!pre_ok) begin
            frame_err <= 1'b1;
            locked    <= 1'b0;
            // an L that breaks the sequence may itself be the next preamble's lead
            if (ival == IV_L) begin
              state     <= PRE;
              pulse_idx <= 2'd1;
            end else begin
              state <= HUNT;
            end
          end else if (pre_match) begin
            pre_type  <= pre_found;
            shreg     <= '0;
            parity    <= 1'b0;
            bit_idx   <= 6'd4;
            half_flag <= 1'b0;
            state     <= DATA;
          end else begin
            if (pulse_idx == 2'd1)
              pre_second <= ival;
            pulse_idx <= pulse_idx + 2'd1;
          end
        end
        DATA: if (edge_det) begin
          if (data_bad) begin
            frame_err <= 1'b1;
            locked    <= 1'b0;
            state     <= HUNT;
          end else if (bit_done) begin
            shreg     <= {bit_val, shreg[27:1]};
            parity    <= parity ^ bit_val;
            bit_idx   <= bit_idx + 6'd1;
            half_flag <= 1'b0;
            if (bit_idx == 6'd31)
              state <= DONE;
          end else begin
            half_flag <= 1'b1;
          end
        end
        DONE: begin
          if (!parity) begin
            sample       <= shreg[23:0];
            v_bit        <= shreg[24];
            u_bit        <= shreg[25];
            c_bit        <= shreg[26];
            is_right     <= (pre_type == PT_W);
            block_start  <= (pre_type == PT_B);
            sample_valid <= 1'b1;
            locked       <= 1'b1;
          end else begin
            parity_err <= 1'b1;
            locked     <= 1'b0;
          end
          // the edge that closed slot 31 opened the next preamble's L
          state     <= PRE;
          pulse_idx <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spdif_rx_decoder.sv
// Bench for spdif_rx_decoder: drives biphase-mark subframes and scoreboards the
// sample/parity/frame strobes against expectations queued at stimulus time.
module tb_spdif_rx_decoder;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        spdif_in = 1'b0;
  logic [23:0] sample;
  logic        sample_valid, is_right, block_start;
  logic        v_bit, u_bit, c_bit;
  logic        parity_err, frame_err, locked;

  spdif_rx_decoder dut (
    .clk_100mhz  (clk_100mhz),
    .rst         (rst),
    .spdif_in    (spdif_in),
    .sample      (sample),
    .sample_valid(sample_valid),
    .is_right    (is_right),
    .block_start (block_start),
    .v_bit       (v_bit),
    .u_bit       (u_bit),
    .c_bit       (c_bit),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .locked      (locked)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  localparam int K_VALID = 0;
  localparam int K_PERR  = 1;
  localparam int K_FERR  = 2;

  typedef struct {
    int          kind;
    logic [23:0] smp;
    logic        rt;
    logic        bs;
    logic [2:0]  vuc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned n_total = 0;
  int unsigned n_bad   = 0;
  bit          mon_en  = 1'b0;
  logic        prev_strobe = 1'b0;
  logic [23:0] last_smp = '0;
  int unsigned cell_lo = 16;
  int unsigned cell_hi = 16;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  always @(negedge clk_100mhz) begin
    if (rst)
      last_smp = '0;
    if (mon_en && (sample_valid || parity_err || frame_err)) begin
      check("onehot", $countones({sample_valid, parity_err, frame_err}), 1);
      check("pulse_width", {31'd0, prev_strobe}, 0);
      if (sb_q.size() == 0) begin
        check("unexpected", {29'd0, sample_valid, parity_err, frame_err}, 0);
      end else begin
        mon_e = sb_q.pop_front();
        case (mon_e.kind)
          K_VALID: begin
            check("valid", {31'd0, sample_valid}, 1);
            check("sample", {8'd0, sample}, {8'd0, mon_e.smp});
            check("is_right", {31'd0, is_right}, {31'd0, mon_e.rt});
            check("block_start", {31'd0, block_start}, {31'd0, mon_e.bs});
            check("vuc", {29'd0, v_bit, u_bit, c_bit}, {29'd0, mon_e.vuc});
            check("lock_valid", {31'd0, locked}, 1);
            last_smp = mon_e.smp;
          end
          K_PERR: begin
            check("perr", {31'd0, parity_err}, 1);
            check("perr_hold", {8'd0, sample}, {8'd0, last_smp});
            check("lock_perr", {31'd0, locked}, 0);
          end
          default: begin
            check("ferr", {31'd0, frame_err}, 1);
            check("lock_ferr", {31'd0, locked}, 0);
          end
        endcase
      end
    end
    prev_strobe = sample_valid | parity_err | frame_err;
  end

  task automatic toggle_hold(input int unsigned cells);
    spdif_in = ~spdif_in;
    for (int unsigned i = 0; i < cells; i++)
      repeat ($urandom_range(cell_hi, cell_lo)) @(negedge clk_100mhz);
  endtask

  // ptype: 0 = B, 1 = M, 2 = W; bad_slot/rst_slot of 0 means none
  task automatic send_subframe(input int ptype, input logic [23:0] smp,
                               input logic v, input logic u, input logic c,
                               input bit flip_p, input int unsigned bad_slot,
                               input int unsigned rst_slot);
    logic [27:0] d;
    exp_t        e;
    d = {1'b0, c, u, v, smp};
    d[27] = (^d[26:0]) ^ flip_p;
    e.kind = flip_p ? K_PERR : K_VALID;
    if (bad_slot != 0)
      e.kind = K_FERR;
    e.smp = smp;
    e.rt  = (ptype == 2);
    e.bs  = (ptype == 0);
    e.vuc = {v, u, c};
    if (rst_slot == 0)
      sb_q.push_back(e);
    case (ptype)
      0: begin toggle_hold(3); toggle_hold(1); toggle_hold(1); toggle_hold(3); end
      1: begin toggle_hold(3); toggle_hold(3); toggle_hold(1); toggle_hold(1); end
      default: begin toggle_hold(3); toggle_hold(2); toggle_hold(1); toggle_hold(2); end
    endcase
    for (int unsigned s = 4; s < 32; s++) begin
      if (s == rst_slot)
        rst = 1'b1;
      if (s == bad_slot) begin
        spdif_in = ~spdif_in;
        repeat (70) @(negedge clk_100mhz);
      end else if (d[s-4]) begin
        toggle_hold(1);
        toggle_hold(1);
      end else begin
        toggle_hold(2);
      end
      if (s == rst_slot) begin
        check("midrst_sample", {8'd0, sample}, 0);
        check("midrst_flags", {23'd0, sample_valid, is_right, block_start, v_bit, u_bit,
                               c_bit, parity_err, frame_err, locked}, 0);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100mhz);
      spdif_in = ~spdif_in;
    end
    mon_en = 1'b1;
    check("rst_sample", {8'd0, sample}, 0);
    check("rst_flags", {23'd0, sample_valid, is_right, block_start, v_bit, u_bit,
                        c_bit, parity_err, frame_err, locked}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100mhz);
      spdif_in = ~spdif_in;
      check("post_rst_quiet", {28'd0, sample_valid, parity_err, frame_err, locked}, 0);
    end
    repeat (100) @(negedge clk_100mhz);

    send_subframe(0, 24'h123456, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    send_subframe(2, 24'hFEDCBA, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
    send_subframe(1, 24'h0A0B0C, 1'b0, 1'b1, 1'b0, 1'b1, 0, 0);
    send_subframe(2, 24'h111111, 1'b0, 1'b0, 1'b0, 1'b0, 12, 0);
    send_subframe(1, 24'h654321, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0);
    send_subframe(2, 24'h00ABCD, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0);

    cell_lo = 14;
    cell_hi = 19;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] r;
      r = $urandom;
      send_subframe((k % 2 == 1) ? 2 : ((k == 0) ? 0 : 1), r[23:0], r[24], r[25], r[26],
                    1'b0, 0, (k == 20) ? 10 : 0);
    end

    spdif_in = ~spdif_in;
    for (int i = 0; i < 300 && sb_q.size() != 0; i++)
      @(negedge clk_100mhz);
    check("drain", sb_q.size(), 0);
    repeat (20) @(negedge clk_100mhz);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
